uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` transmitter between several byte requesters. It accepts one byte at a time from the winning requester and drives the transmitter's `txDv` / `incomingByte` inputs. It then holds off further grants until the transmitter reports `txDone`, or until a watchdog expires. It sits between the application-side byte sources and the single `uart_tx` instance; `clocksPerBit` is wired to `uart_tx` directly and is not touched by this block.

---
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between several byte requesters.
// Launches one byte per grant, then waits for txDone or a watchdog expiry before granting again.
module uart_tx_arbiter #(
  parameter int unsigned numRequesters = 4,
  parameter int unsigned timeoutCycles = 1000000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [numRequesters-1:0]             reqValid,
  input  logic [8*numRequesters-1:0]           reqByte,
  output logic [numRequesters-1:0]             reqReady,
  input  logic                                 txActive,
  input  logic                                 txDone,
  output logic                                 txDv,
  output logic [7:0]                           txByteOut,
  output logic [$clog2(numRequesters)-1:0]     grantId,
  output logic                                 busy,
  output logic                                 txTimeout
);

  localparam int unsigned IW       = $clog2(numRequesters);
  localparam logic [31:0] TMO_LAST = 32'(timeoutCycles - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT_DONE
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [numRequesters-1:0] r_ready, w_ready_nxt;
  logic                     r_dv, w_dv_nxt;
  logic [7:0]               r_byte, w_byte_nxt;
  logic [IW-1:0]            r_gid, w_gid_nxt;
  logic [IW-1:0]            r_last, w_last_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     r_tmo, w_tmo_nxt;
  logic [31:0]              r_wd, w_wd_nxt;

  logic                     w_found;
  logic [IW-1:0]            w_winner;
  int unsigned              w_idx;

  // Search starts one past the last winner and wraps, so the last winner is checked last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int unsigned off = 1; off <= numRequesters; off++) begin
      w_idx = (32'(r_last) + off) % numRequesters;
      if (!w_found && reqValid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = IW'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = '0;
    w_dv_nxt    = 1'b0;
    w_byte_nxt  = r_byte;
    w_gid_nxt   = r_gid;
    w_last_nxt  = r_last;
    w_busy_nxt  = r_busy;
    w_tmo_nxt   = 1'b0;
    w_wd_nxt    = r_wd;
    case (r_state)
      S_IDLE: begin
        if (w_found && !txActive) begin
          w_ready_nxt = numRequesters'(1) << w_winner;
          w_dv_nxt    = 1'b1;
          w_byte_nxt  = reqByte[{w_winner, 3'b000} +: 8];
          w_gid_nxt   = w_winner;
          w_last_nxt  = w_winner;
          w_busy_nxt  = 1'b1;
          w_wd_nxt    = '0;
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        w_wd_nxt = r_wd + 32'd1;
        // txDone wins over a coincident watchdog expiry.
        if (txDone) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_wd == TMO_LAST) begin
          w_busy_nxt  = 1'b0;
          w_tmo_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= '0;
      r_dv    <= 1'b0;
      r_byte  <= '0;
      r_gid   <= '0;
      r_last  <= IW'(numRequesters - 1);
      r_busy  <= 1'b0;
      r_tmo   <= 1'b0;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_dv    <= w_dv_nxt;
      r_byte  <= w_byte_nxt;
      r_gid   <= w_gid_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
      r_tmo   <= w_tmo_nxt;
      r_wd    <= w_wd_nxt;
    end
  end

  assign reqReady  = r_ready;
  assign txDv      = r_dv;
  assign txByteOut = r_byte;
  assign grantId   = r_gid;
  assign busy      = r_busy;
  assign txTimeout = r_tmo;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus pushes expected launches and
// timeouts; a negedge monitor pops and compares whenever the DUT strobes txDv/txTimeout.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 60;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] reqValid;
  logic [8*NR-1:0] reqByte;
  logic [NR-1:0] reqReady;
  logic          txActive, txDone;
  logic          txDv;
  logic [7:0]    txByteOut;
  logic [1:0]    grantId;
  logic          busy, txTimeout;

  uart_tx_arbiter #(.numRequesters(NR), .timeoutCycles(TO)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqByte(reqByte),
    .reqReady(reqReady), .txActive(txActive), .txDone(txDone), .txDv(txDv),
    .txByteOut(txByteOut), .grantId(grantId), .busy(busy), .txTimeout(txTimeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    int         id;
    logic [7:0] b;
  } launch_t;

  launch_t lq[$];
  int      tq[$];
  int      n_cmp = 0;
  int      n_bad = 0;
  bit      mon_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_launch(input int c, input int id, input logic [7:0] b);
    launch_t e;
    e.c = c; e.id = id; e.b = b;
    lq.push_back(e);
  endtask

  task automatic done_pulse_at(input int c);
    wait_to(c);
    txDone = 1'b1;
    tick();
    txDone = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txDv"}, 32'(txDv), 0);
    chk({tag, "_reqReady"}, 32'(reqReady), 0);
    chk({tag, "_txByteOut"}, 32'(txByteOut), 0);
    chk({tag, "_grantId"}, 32'(grantId), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_txTimeout"}, 32'(txTimeout), 0);
  endtask

  // Monitor: every launch and timeout must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (txDv === 1'b1) begin
        if (lq.size() == 0) chk("unexpected_txDv", 32'(txDv), 0);
        else begin
          launch_t e;
          e = lq.pop_front();
          chk("launch_cycle", 32'(cyc), 32'(e.c));
          chk("grantId", 32'(grantId), 32'(e.id));
          chk("txByteOut", 32'(txByteOut), 32'(e.b));
          chk("reqReady_onehot", 32'(reqReady), 32'(1) << e.id);
          chk("busy_at_launch", 32'(busy), 1);
        end
      end else begin
        chk("stray_reqReady", 32'(reqReady), 0);
      end
      if (txTimeout !== 1'b0) begin
        if (tq.size() == 0) chk("unexpected_txTimeout", 32'(txTimeout), 0);
        else chk("timeout_cycle", 32'(cyc), 32'(tq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int c, l, l2, k;
    reset = 1'b1; reqValid = '0; reqByte = '0; txActive = 1'b0; txDone = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    // Single requester, txDone 50 cycles after launch.
    c = cyc;
    reqByte[7:0] = 8'h07;
    reqValid = 4'b0001;
    push_launch(c + 1, 0, 8'h07);
    tick();
    reqValid = '0;
    chk("t1_busy_high", 32'(busy), 1);
    done_pulse_at(c + 1 + 50);
    chk("t1_busy_cleared", 32'(busy), 0);
    done_pulse_at(cyc + 3);
    repeat (3) tick();

    // Round-robin: fresh pointer, all requesters held valid.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    reqByte = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    reqValid = 4'b1111;
    c = cyc;
    for (int i = 0; i < 5; i++) push_launch(c + 1 + 7*i, i % 4, 8'hA0 + 8'(i % 4));
    tick();
    for (int i = 0; i < 4; i++) done_pulse_at(c + 1 + 7*i + 5);
    wait_to(c + 29);
    reqValid = '0;
    done_pulse_at(c + 34);
    tick();

    // Skip and wrap: grant 3, then 1010 -> 1 then 3.
    reqByte = {8'h33, 8'h22, 8'h11, 8'h00};
    reqValid = 4'b1000;
    c = cyc; l = c + 1;
    push_launch(l, 3, 8'h33);
    push_launch(l + 7, 1, 8'h11);
    push_launch(l + 14, 3, 8'h33);
    tick();
    reqValid = 4'b1010;
    done_pulse_at(l + 5);
    done_pulse_at(l + 12);
    wait_to(l + 14);
    reqValid = '0;
    done_pulse_at(l + 19);
    tick();

    // Back-pressure: txActive holds off the launch until it falls.
    reqByte = {8'h00, 8'h00, 8'h00, 8'h5A};
    txActive = 1'b1;
    reqValid = 4'b0001;
    repeat (10) tick();
    k = cyc;
    txActive = 1'b0;
    push_launch(k + 1, 0, 8'h5A);
    tick();
    reqValid = '0;
    done_pulse_at(k + 4);
    tick();

    // Watchdog expiry, then the pending requester is granted; then txDone coincident with expiry.
    reqByte = {8'h00, 8'h88, 8'h77, 8'h00};
    reqValid = 4'b0110;
    c = cyc; l = c + 1; l2 = l + TO + 1;
    push_launch(l, 1, 8'h77);
    tq.push_back(l + TO);
    push_launch(l2, 2, 8'h88);
    tick();
    reqValid = 4'b0100;
    wait_to(l + TO);
    chk("t5_busy_after_timeout", 32'(busy), 0);
    wait_to(l2);
    reqValid = '0;
    done_pulse_at(l2 + TO - 1);
    chk("t5_busy_after_done_at_expiry", 32'(busy), 0);
    repeat (4) tick();

    // Reset mid-frame while the transmitter is still active.
    reqByte = {8'h99, 8'h00, 8'h00, 8'hC3};
    reqValid = 4'b1000;
    c = cyc; l = c + 1;
    push_launch(l, 3, 8'h99);
    tick();
    reqValid = '0;
    wait_to(l + 3);
    txActive = 1'b1;
    wait_to(l + 4);
    reset = 1'b1;
    reqValid = 4'b1111;
    tick();
    chk_reset_vals("midreset");
    tick();
    reset = 1'b0;
    repeat (5) tick();
    k = cyc;
    txActive = 1'b0;
    push_launch(k + 1, 0, 8'hC3);
    tick();
    reqValid = '0;
    done_pulse_at(k + 4);
    repeat (3) tick();

    chk("launch_queue_drained", 32'(lq.size()), 0);
    chk("timeout_queue_drained", 32'(tq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
